// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, FSM encoding and FIPS-197 byte slicing helper.
package aes_pkg;
   localparam int AES_BLOCK_BITS = 128;
   localparam int AES_NBYTES     = 16;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int byte_off(input int i);
      return AES_BLOCK_BITS - 1 - 8 * i;
   endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational Rijndael inverse S-box lookup.
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [7:0] LUT [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };
   assign y = LUT[a];
endmodule

// File: rtl/aes_inv_sub_bytes_iter.sv
// aes_inv_sub_bytes_iter: iterative InvSubBytes, LANES bytes per cycle,
// valid/ready in and out with no overlap between accept and deliver.
module aes_inv_sub_bytes_iter import aes_pkg::*; #(
   parameter int LANES = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [AES_BLOCK_BITS-1:0] in_state,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [AES_BLOCK_BITS-1:0] out_state,
   output logic                      busy
);
   localparam int NCHUNK = AES_NBYTES / LANES;
   localparam int CW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   state_t                    state, nstate;
   logic [AES_BLOCK_BITS-1:0] work, wnext;
   logic [CW-1:0]             cnt;
   logic                      last;
   logic [7:0]                sb_in [LANES];
   logic [7:0]                sb_out[LANES];
   assign last = cnt == CW'(NCHUNK - 1);
   always_comb begin
      wnext = work;
      for (int k = 0; k < LANES; k++) begin
         sb_in[k] = work[byte_off(int'(cnt) * LANES + k) -: 8];
         wnext[byte_off(int'(cnt) * LANES + k) -: 8] = sb_out[k];
      end
   end
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      aes_inv_sbox u_sbox (.a(sb_in[k]), .y(sb_out[k]));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         cnt   <= '0;
      end else begin
         state <= nstate;
         if (state == IDLE && in_valid) begin
            work <= in_state;
            cnt  <= '0;
         end else if (state == RUN) begin
            work <= wnext;
            cnt  <= last ? '0 : cnt + 1'b1;
         end
      end
   end
   // work is only exposed once every chunk has been substituted
   always_comb begin
      nstate    = state;
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      busy      = state != IDLE;
      out_state = out_valid ? work : '0;
      if (state == IDLE && in_valid) nstate = RUN;
      else if (state == RUN && last) nstate = DONE;
      else if (state == DONE && out_ready) nstate = IDLE;
   end
endmodule

// File: tb/tb_aes_inv_sub_bytes_iter.sv
// tb_aes_inv_sub_bytes_iter: LANES=1..16 instances on shared stimulus, checked
// each cycle against a GF(2^8)-derived inverse S-box and handshake model.
module tb_aes_inv_sub_bytes_iter;
   localparam int NI = 5;
   logic         clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic [127:0] in_state = '0;
   logic         ir[NI], ov[NI], bz[NI];
   logic [127:0] os[NI];
   int           errors = 0, checks = 0, cyc = 0;
   bit           chk_on = 0;
   logic [7:0]   fsb[256], isb[256];
   int           ph[NI], rem[NI], acc[NI];
   logic [127:0] mres[NI];
   logic         pov[NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes_inv_sub_bytes_iter #(.LANES(1 << g)) dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]), .in_state(in_state),
         .out_valid(ov[g]), .out_ready(out_ready), .out_state(os[g]), .busy(bz[g]));
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [15:0] t = {b, b};
      t = t << n;
      return t[15:8];
   endfunction

   function automatic logic [127:0] inv_sub(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = isb[v[127-8*i -: 8]];
      return r;
   endfunction

   task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lane_inst=%0d got=%h want=%h t=%0t", nm, i, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NI; i++)
         if (rst) ph[i] <= 0;
         else if (ph[i] == 0 && in_valid) begin
            ph[i] <= 1; rem[i] <= 16 >> i; mres[i] <= inv_sub(in_state); acc[i] <= cyc + 1;
         end else if (ph[i] == 1) begin
            rem[i] <= rem[i] - 1;
            if (rem[i] == 1) ph[i] <= 2;
         end else if (ph[i] == 2 && out_ready) ph[i] <= 0;
   end

   always @(negedge clk) if (chk_on)
      for (int i = 0; i < NI; i++) begin
         chk("in_ready", i, 128'(ir[i]), 128'(ph[i] == 0));
         chk("out_valid", i, 128'(ov[i]), 128'(ph[i] == 2));
         chk("busy", i, 128'(bz[i]), 128'(ph[i] != 0));
         chk("out_state", i, os[i], ph[i] == 2 ? mres[i] : 128'h0);
         if (ov[i] && !pov[i]) chk("latency", i, 128'(cyc - acc[i]), 128'(16 >> i));
         pov[i] <= ov[i];
      end

   task automatic step(); @(negedge clk); endtask

   task automatic send(input logic [127:0] v);
      int n = 0;
      while (!(ir[0] && ir[1] && ir[2] && ir[3] && ir[4]) && n < 60) begin step(); n++; end
      if (n == 60) chk("idle_timeout", 0, 1, 0);
      in_valid = 1; in_state = v;
      step();
      in_valid = 0;
   endtask

   task automatic expect_result(input string nm, input logic [127:0] lit);
      bit got[NI] = '{default: 0};
      int n = 0;
      while (!(got[0] && got[1] && got[2] && got[3] && got[4]) && n < 40) begin
         for (int i = 0; i < NI; i++)
            if (ov[i] && !got[i]) begin chk(nm, i, os[i], lit); got[i] = 1; end
         step(); n++;
      end
      if (n == 40) chk({nm, "_timeout"}, 0, 1, 0);
   endtask

   localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

   initial begin
      logic [127:0] v, lit;
      for (int x = 0; x < 256; x++) begin
         logic [7:0] b = 0, s;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
         s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
         fsb[x] = s; isb[s] = 8'(x);
      end
      chk("model_fsb00", 0, 128'(fsb[8'h00]), 128'h63);
      chk("model_fsb53", 0, 128'(fsb[8'h53]), 128'hed);
      chk("model_isb16", 0, 128'(isb[8'h16]), 128'hff);
      chk("model_fips", 0, inv_sub(FIPS_IN), FIPS_OUT);
      repeat (2) step();
      chk_on = 1;
      rst = 0;
      step();
      send(FIPS_IN);             expect_result("fips", FIPS_OUT);
      send({16{8'h63}});         expect_result("all63", {16{8'h00}});
      send({16{8'h00}});         expect_result("all00", {16{8'h52}});
      send({16{8'h16}});         expect_result("all16", {16{8'hff}});
      for (int b = 0; b < 16; b++) begin
         for (int j = 0; j < 16; j++) begin
            v[127-8*j -: 8] = fsb[16*b + j];
            lit[127-8*j -: 8] = 8'(16*b + j);
         end
         send(v); expect_result("roundtrip", lit);
      end
      // backpressure with in_valid held high in DONE
      out_ready = 0;
      send(FIPS_IN);
      for (int n = 0; n < 40 && !(ov[0] && ov[1] && ov[2] && ov[3] && ov[4]); n++) step();
      in_valid = 1;
      for (int n = 0; n < 5; n++) begin
         in_state = {$urandom, $urandom, $urandom, $urandom};
         chk("hold_state", 2, os[2], FIPS_OUT);
         chk("hold_in_ready", 2, 128'(ir[2]), 0);
         step();
      end
      out_ready = 1;
      step();
      in_valid = 0;
      chk("release_in_ready", 2, 128'(ir[2]), 1);
      repeat (20) step();
      // reset two cycles after acceptance
      send(FIPS_IN);
      step();
      rst = 1;
      step();
      rst = 0;
      chk("rst_out_valid", 2, 128'(ov[2]), 0);
      chk("rst_out_state", 2, os[2], 0);
      step();
      chk("rst_in_ready", 2, 128'(ir[2]), 1);
      send(FIPS_IN);             expect_result("after_rst", FIPS_OUT);
      // in_state churn while busy
      for (int r = 0; r < 8; r++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         send(v);
         for (int n = 0; n < 20; n++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            step();
         end
      end
      repeat (5) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
